// File: rtl/seg_scan_display.sv
// seg_scan_display
//   Time-multiplexed driver for a common-anode seven-segment display.
//   The digits are scanned one slot at a time. Each slot starts with GUARD
//   dark cycles to suppress ghosting. val and the three masks are captured
//   once per frame, so the display never tears in the middle of a frame.
//   Digits can be blanked, blinked, or given a decimal point.
//
//   Optional feature macro: SEG_LZ_SUPPRESS_EN
//     When defined, leading zero digits are dark, but their dp still follows
//     dp_mask. Digit 0 is never suppressed.
//     When undefined, no suppression logic is built and a zero decodes as C0.
//
// Parameters
//   DIGITS     number of multiplexed digits (2..8)
//   SCAN_DIV   fs cycles per digit slot (must exceed GUARD)
//   GUARD      dark cycles at the start of each slot (at least 1)
//   BLINK_DIV  complete frames per blink-phase toggle (at least 1)
//
// Ports
//   fs          in   clock, rising edge
//   rst         in   synchronous active-high reset
//   val         in   packed hex digit codes, digit i = val[4i+3:4i]
//   blink_mask  in   per-digit blink enable
//   blank_mask  in   per-digit forced dark
//   dp_mask     in   per-digit decimal point
//   led_dig     out  active-low digit enables (registered)
//   display     out  active-low segments {dp,g,f,e,d,c,b,a} (registered)
//   frame       out  one-cycle pulse after each frame start (registered)
module seg_scan_display #(
  parameter int DIGITS    = 6,
  parameter int SCAN_DIV  = 1000,
  parameter int GUARD     = 8,
  parameter int BLINK_DIV = 50
) (
  input  logic                  fs,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   val,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     led_dig,
  output logic [7:0]            display,
  output logic                  frame
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int IW = $clog2(DIGITS);
  localparam int FW = $clog2(BLINK_DIV + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] GUARD_END = SW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [FW-1:0] FRM_LAST  = FW'(BLINK_DIV - 1);

  // Hex to segments {g,f,e,d,c,b,a}, active low.
  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = 7'h40;
      4'h1:    seg = 7'h79;
      4'h2:    seg = 7'h24;
      4'h3:    seg = 7'h30;
      4'h4:    seg = 7'h19;
      4'h5:    seg = 7'h12;
      4'h6:    seg = 7'h02;
      4'h7:    seg = 7'h78;
      4'h8:    seg = 7'h00;
      4'h9:    seg = 7'h10;
      4'hA:    seg = 7'h08;
      4'hB:    seg = 7'h03;
      4'hC:    seg = 7'h46;
      4'hD:    seg = 7'h21;
      4'hE:    seg = 7'h06;
      4'hF:    seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

  logic [SW-1:0]         slot_cnt;
  logic [IW-1:0]         idx;
  logic [FW-1:0]         frame_cnt;
  logic                  blink_phase;
  logic                  started;     // a frame is in progress, so the next frame start completes one
  logic [4*DIGITS-1:0]   snap_val;
  logic [DIGITS-1:0]     snap_blink;
  logic [DIGITS-1:0]     snap_blank;
  logic [DIGITS-1:0]     snap_dp;

  logic                  frame_start;
  logic                  slot_wrap;
  logic [3:0]            code;
  logic [DIGITS-1:0]     led_next;
  logic [7:0]            display_next;

  assign frame_start = (slot_cnt == {SW{1'b0}}) && (idx == {IW{1'b0}});
  assign slot_wrap   = (slot_cnt == SLOT_LAST);
  assign code        = snap_val[{idx, 2'b00} +: 4];

`ifdef SEG_LZ_SUPPRESS_EN
  logic [DIGITS-1:0]     lz_digit;
  logic                  upper_zero;

  // A digit is a leading zero when it and every digit above it are zero.
  always_comb begin
    lz_digit   = {DIGITS{1'b0}};
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero  = upper_zero && (snap_val[4*i +: 4] == 4'h0);
      lz_digit[i] = upper_zero;
    end
  end
`endif

  // Next digit enables and segments, computed from the current counter state.
  always_comb begin
    led_next     = {DIGITS{1'b1}};
    display_next = 8'hFF;
    if (slot_cnt < GUARD_END) begin
      led_next     = {DIGITS{1'b1}};
      display_next = 8'hFF;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        led_next[i] = (idx != IW'(i));
      end
      if (snap_blank[idx]) begin
        display_next = 8'hFF;
      end else if (blink_phase && snap_blink[idx]) begin
        display_next = 8'hFF;
`ifdef SEG_LZ_SUPPRESS_EN
      end else if (lz_digit[idx]) begin
        display_next = {~snap_dp[idx], 7'h7F};
`endif
      end else begin
        display_next = {~snap_dp[idx], seg_decode(code)};
      end
    end
  end

  // Scan counters, frame snapshot, blink phase and registered outputs.
  always_ff @(posedge fs) begin
    if (rst) begin
      slot_cnt    <= {SW{1'b0}};
      idx         <= {IW{1'b0}};
      frame_cnt   <= {FW{1'b0}};
      blink_phase <= 1'b0;
      started     <= 1'b0;
      snap_val    <= {(4*DIGITS){1'b0}};
      snap_blink  <= {DIGITS{1'b0}};
      snap_blank  <= {DIGITS{1'b0}};
      snap_dp     <= {DIGITS{1'b0}};
      led_dig     <= {DIGITS{1'b1}};
      display     <= 8'hFF;
      frame       <= 1'b0;
    end else begin
      if (slot_wrap) begin
        slot_cnt <= {SW{1'b0}};
        if (idx == IDX_LAST) begin
          idx <= {IW{1'b0}};
        end else begin
          idx <= idx + IW'(1);
        end
      end else begin
        slot_cnt <= slot_cnt + SW'(1);
      end

      if (frame_start) begin
        snap_val   <= val;
        snap_blink <= blink_mask;
        snap_blank <= blank_mask;
        snap_dp    <= dp_mask;
        started    <= 1'b1;
        // The first frame start after reset does not end a complete frame.
        if (started) begin
          if (frame_cnt == FRM_LAST) begin
            frame_cnt   <= {FW{1'b0}};
            blink_phase <= ~blink_phase;
          end else begin
            frame_cnt <= frame_cnt + FW'(1);
          end
        end
      end

      led_dig <= led_next;
      display <= display_next;
      frame   <= frame_start;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb_seg_scan_display
//   Bench for seg_scan_display with DIGITS=4, SCAN_DIV=4, GUARD=1, BLINK_DIV=2.
//   Expected outputs are queued one cycle ahead. A negedge monitor pops them
//   and compares them against the DUT.
module tb_seg_scan_display;

  localparam int DIGITS    = 4;
  localparam int SCAN_DIV  = 4;
  localparam int GUARD     = 1;
  localparam int BLINK_DIV = 2;
  localparam int FRAME_LEN = DIGITS * SCAN_DIV;

  logic        fs = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] val = 16'h1234;
  logic [3:0]  blink_mask = 4'h0;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  dp_mask = 4'h0;
  logic [3:0]  led_dig;
  logic [7:0]  display;
  logic        frame;

  seg_scan_display #(
    .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV), .GUARD(GUARD), .BLINK_DIV(BLINK_DIV)
  ) dut (
    .fs(fs), .rst(rst), .val(val), .blink_mask(blink_mask),
    .blank_mask(blank_mask), .dp_mask(dp_mask),
    .led_dig(led_dig), .display(display), .frame(frame)
  );

  initial forever #5 fs = ~fs;

  typedef struct {
    logic [3:0] led;
    logic [7:0] disp;
    logic       frm;
    int         id;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   fails = 0;
  int   tick_no = 0;
  exp_t mon_e;

  // Segment codes {dp,g,f,e,d,c,b,a}, with dp off.
  localparam logic [7:0] SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // Monitor: compare the DUT outputs against the oldest queued expectation.
  always @(negedge fs) begin
    if (sbq.size() > 0) begin
      mon_e = sbq.pop_front();
      checks++;
      if (led_dig !== mon_e.led) begin
        fails++;
        $display("FAIL led_dig tick=%0d got=%b exp=%b", mon_e.id, led_dig, mon_e.led);
      end
      checks++;
      if (display !== mon_e.disp) begin
        fails++;
        $display("FAIL display tick=%0d got=%h exp=%h", mon_e.id, display, mon_e.disp);
      end
      checks++;
      if (frame !== mon_e.frm) begin
        fails++;
        $display("FAIL frame tick=%0d got=%b exp=%b", mon_e.id, frame, mon_e.frm);
      end
    end
  end

  // Queue the expectation for the next rising edge, then let that edge pass.
  task automatic tick(input logic [3:0] led, input logic [7:0] disp, input logic frm);
    exp_t e;
    @(negedge fs);
    #1;
    e.led  = led;
    e.disp = disp;
    e.frm  = frm;
    e.id   = tick_no;
    tick_no++;
    sbq.push_back(e);
    @(posedge fs);
    #1;
  endtask

  // Reference model state: edges since reset release, and the frame snapshot.
  int          t = 0;
  logic [15:0] s_val;
  logic [3:0]  s_bl, s_bk, s_dp;

  function automatic logic [7:0] mdisp(input logic [15:0] v, input logic [3:0] bl,
                                       input logic [3:0] bk, input logic [3:0] dp,
                                       input logic ph, input int d);
    logic [3:0] c;
    logic [7:0] s;
    logic       nz;
    c  = v[4*d +: 4];
    s  = SEG[c];
    nz = 1'b0;
    for (int j = d; j < DIGITS; j++) begin
      if (v[4*j +: 4] != 4'h0) nz = 1'b1;
    end
    if (bk[d]) return 8'hFF;
    if (ph && bl[d]) return 8'hFF;
`ifdef SEG_LZ_SUPPRESS_EN
    if (d != 0 && !nz) return {~dp[d], 7'h7F};
`endif
    return {~dp[d], s[6:0]};
  endfunction

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick(4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    t = 0;
  endtask

  task automatic run_model(input int n);
    int         p, d, sl;
    logic       ph;
    logic [3:0] lm;
    repeat (n) begin
      p  = t % FRAME_LEN;
      d  = p / SCAN_DIV;
      sl = p % SCAN_DIV;
      if (p == 0) begin
        s_val = val; s_bl = blink_mask; s_bk = blank_mask; s_dp = dp_mask;
      end
      ph = (((t / FRAME_LEN) / BLINK_DIV) % 2) == 1;
      if (sl < GUARD) begin
        tick(4'hF, 8'hFF, p == 0);
      end else begin
        lm = 4'b0001 << d;
        tick(~lm, mdisp(s_val, s_bl, s_bk, s_dp, ph, d), 1'b0);
      end
      t++;
    end
  endtask

  typedef struct {
    logic [15:0]     v;
    logic [3:0]      bl, bk, dp;
    logic [3:0][7:0] e;   // expected display, digit 3 .. digit 0
  } vec_t;

  vec_t vt[8];

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'h1234, 4'h0, 4'h0, 4'h0,    {8'hF9, 8'hA4, 8'hB0, 8'h99}};
    vt[1] = '{16'h1234, 4'h0, 4'h1, 4'h3,    {8'hF9, 8'hA4, 8'h30, 8'hFF}};
`ifdef SEG_LZ_SUPPRESS_EN
    vt[2] = '{16'h0070, 4'h0, 4'h0, 4'h0,    {8'hFF, 8'hFF, 8'hF8, 8'hC0}};
    vt[5] = '{16'h0000, 4'h0, 4'h0, 4'hE,    {8'h7F, 8'h7F, 8'h7F, 8'hC0}};
    vt[7] = '{16'h0305, 4'h0, 4'h0, 4'h0,    {8'hFF, 8'hB0, 8'hC0, 8'h92}};
`else
    vt[2] = '{16'h0070, 4'h0, 4'h0, 4'h0,    {8'hC0, 8'hC0, 8'hF8, 8'hC0}};
    vt[5] = '{16'h0000, 4'h0, 4'h0, 4'hE,    {8'h40, 8'h40, 8'h40, 8'hC0}};
    vt[7] = '{16'h0305, 4'h0, 4'h0, 4'h0,    {8'hC0, 8'hB0, 8'hC0, 8'h92}};
`endif
    vt[3] = '{16'hCDEF, 4'hF, 4'h0, 4'h8,    {8'h46, 8'hA1, 8'h86, 8'h8E}};
    vt[4] = '{16'h5678, 4'h0, 4'h0, 4'h5,    {8'h92, 8'h02, 8'hF8, 8'h00}};
    vt[6] = '{16'h9AB0, 4'h0, 4'h8, 4'h0,    {8'hFF, 8'h88, 8'h83, 8'hC0}};

    // Reset state, then the basic scan with frame pulses over three frames.
    do_reset(2);
    run_model(3 * FRAME_LEN);

    // Change val mid-frame: the old digits hold until the next frame start.
    run_model(6);
    val = 16'h5678;
    run_model(10 + FRAME_LEN);

    // Blink digit 1 from reset: two frames lit, two dark, then lit again.
    val = 16'h1234;
    blink_mask = 4'b0010;
    do_reset(1);
    run_model(5 * FRAME_LEN);
    blink_mask = 4'b0000;

    // Reset during digit 2's slot aborts the frame and restarts from digit 0.
    do_reset(1);
    run_model(9);
    do_reset(1);
    run_model(20);

    // Table vectors: one full frame per record, plus the next frame start.
    for (int r = 0; r < 8; r++) begin
      val = vt[r].v; blink_mask = vt[r].bl; blank_mask = vt[r].bk; dp_mask = vt[r].dp;
      do_reset(1);
      for (int p = 0; p < FRAME_LEN; p++) begin
        logic [3:0] lm;
        if ((p % SCAN_DIV) < GUARD) begin
          tick(4'hF, 8'hFF, p == 0);
        end else begin
          lm = 4'b0001 << (p / SCAN_DIV);
          tick(~lm, vt[r].e[p / SCAN_DIV], 1'b0);
        end
      end
      tick(4'hF, 8'hFF, 1'b1);
    end

    @(negedge fs);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain got=%0d exp=0", sbq.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
